// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cnn_pkg
//  Description : Shared definitions for the CNN datapath: default element
//                width, signed element type and the pooled-dimension helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    // Default bits per channel element across the datapath
    localparam int CNN_DATA_WIDTH = 16;

    // One signed two's-complement feature-map element at the default width
    typedef logic signed [CNN_DATA_WIDTH-1:0] elem_t;

    // Pooled output dimension: floor(in_dim / k)
    function automatic int pool_out_dim(input int in_dim, input int k);
        return in_dim / k;
    endfunction

endpackage : cnn_pkg
`default_nettype wire

// File: rtl/pool_max2.sv
`default_nettype none
// ============================================================================
//  Module      : pool_max2
//  Description : Signed two-input maximum for a single feature-map element.
//                Purely combinational; on equality operand a is returned,
//                which is numerically identical to b.
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_max2
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = CNN_DATA_WIDTH
) (
    input  logic signed [DATA_WIDTH-1:0] i_a,
    input  logic signed [DATA_WIDTH-1:0] i_b,
    output logic signed [DATA_WIDTH-1:0] o_max
);

    assign o_max = (i_a >= i_b) ? i_a : i_b;

endmodule : pool_max2
`default_nettype wire

// File: rtl/stream_max_pool.sv
`default_nettype none
// ============================================================================
//  Module      : stream_max_pool
//  Description : Streaming KxK max-pool with stride K. Pixels arrive one per
//                beat in raster order with all channels packed on one bus.
//                A line buffer of OW partial maxima accumulates each window;
//                the window's last pixel loads the single output register.
//                Trailing rows/columns outside the pooled grid are accepted
//                and dropped.
//  Options     : define STREAM_MAX_POOL_RELU_EN to clamp negative output
//                channels to zero at the output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_max_pool
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int InputH     = 28,
    parameter int InputW     = 28,
    parameter int Depth      = 1,
    parameter int POOL_K     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [Depth*DATA_WIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [Depth*DATA_WIDTH-1:0] out_data,
    output logic                        out_last
);

    localparam int OH     = pool_out_dim(InputH, POOL_K);
    localparam int OW     = pool_out_dim(InputW, POOL_K);
    localparam int BUS_W  = Depth * DATA_WIDTH;
    localparam int ROW_W  = $clog2(InputH + 1);
    localparam int COL_W  = $clog2(InputW + 1);
    localparam int PH_W   = $clog2(POOL_K);
    localparam int RIDX_W = $clog2(OH + 1);
    localparam int CIDX_W = $clog2(OW + 1);
    localparam int BUF_AW = (OW > 1) ? $clog2(OW) : 1;

    localparam logic [ROW_W-1:0]  c_ROW_LAST  = ROW_W'(InputH - 1);
    localparam logic [ROW_W-1:0]  c_ROW_GRID  = ROW_W'(OH * POOL_K);
    localparam logic [COL_W-1:0]  c_COL_LAST  = COL_W'(InputW - 1);
    localparam logic [COL_W-1:0]  c_COL_GRID  = COL_W'(OW * POOL_K);
    localparam logic [PH_W-1:0]   c_PH_LAST   = PH_W'(POOL_K - 1);
    localparam logic [RIDX_W-1:0] c_RIDX_LAST = RIDX_W'(OH - 1);
    localparam logic [CIDX_W-1:0] c_CIDX_LAST = CIDX_W'(OW - 1);

    // Position counters: absolute row/col, phase inside the window and
    // pooled index. Phase/index are tracked incrementally so no divider or
    // modulo is needed for non-power-of-two K.
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [PH_W-1:0]   r_row_ph;
    logic [PH_W-1:0]   r_col_ph;
    logic [RIDX_W-1:0] r_row_idx;
    logic [CIDX_W-1:0] r_col_idx;

    logic [BUS_W-1:0]  r_buf [OW];

    logic              r_out_valid;
    logic [BUS_W-1:0]  r_out_data;
    logic              r_out_last;

    logic              w_in_fire;
    logic              w_in_grid;
    logic              w_first;
    logic              w_emit;
    logic              w_last_pos;
    logic [BUF_AW-1:0] w_buf_idx;
    logic [BUS_W-1:0]  w_entry;
    logic [BUS_W-1:0]  w_upd;
    logic [BUS_W-1:0]  w_out_next;

    // Only the output register can stall the input side
    assign in_ready   = !r_out_valid || out_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_in_grid  = (r_row < c_ROW_GRID) && (r_col < c_COL_GRID);
    assign w_first    = (r_row_ph == '0) && (r_col_ph == '0);
    assign w_emit     = w_in_fire && w_in_grid &&
                        (r_row_ph == c_PH_LAST) && (r_col_ph == c_PH_LAST);
    assign w_last_pos = (r_row_idx == c_RIDX_LAST) && (r_col_idx == c_CIDX_LAST);
    assign w_buf_idx  = r_col_idx[BUF_AW-1:0];
    assign w_entry    = r_buf[w_buf_idx];

    // Per-channel datapath: buffer update max and emit max (channel 0 in MSBs)
    for (genvar g = 0; g < Depth; g++) begin : g_ch
        localparam int c_LSB = (Depth - 1 - g) * DATA_WIDTH;

        logic signed [DATA_WIDTH-1:0] w_in_el;
        logic signed [DATA_WIDTH-1:0] w_buf_el;
        logic signed [DATA_WIDTH-1:0] w_upd_max;
        logic signed [DATA_WIDTH-1:0] w_emit_max;

        assign w_in_el  = in_data[c_LSB +: DATA_WIDTH];
        assign w_buf_el = w_entry[c_LSB +: DATA_WIDTH];

        pool_max2 #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_upd_max (
            .i_a   (w_buf_el),
            .i_b   (w_in_el),
            .o_max (w_upd_max)
        );

        pool_max2 #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_emit_max (
            .i_a   (w_buf_el),
            .i_b   (w_in_el),
            .o_max (w_emit_max)
        );

        // The first pixel of a window replaces whatever the entry held
        assign w_upd[c_LSB +: DATA_WIDTH] = w_first ? w_in_el : w_upd_max;

`ifdef STREAM_MAX_POOL_RELU_EN
        assign w_out_next[c_LSB +: DATA_WIDTH] =
            w_emit_max[DATA_WIDTH-1] ? '0 : w_emit_max;
`else
        assign w_out_next[c_LSB +: DATA_WIDTH] = w_emit_max;
`endif
    end

    // Raster position tracking; moves only on an accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row     <= '0;
            r_col     <= '0;
            r_row_ph  <= '0;
            r_col_ph  <= '0;
            r_row_idx <= '0;
            r_col_idx <= '0;
        end else if (w_in_fire) begin
            if (r_col == c_COL_LAST) begin
                r_col     <= '0;
                r_col_ph  <= '0;
                r_col_idx <= '0;
                if (r_row == c_ROW_LAST) begin
                    r_row     <= '0;
                    r_row_ph  <= '0;
                    r_row_idx <= '0;
                end else begin
                    r_row <= r_row + 1'b1;
                    if (r_row_ph == c_PH_LAST) begin
                        r_row_ph  <= '0;
                        r_row_idx <= r_row_idx + 1'b1;
                    end else begin
                        r_row_ph <= r_row_ph + 1'b1;
                    end
                end
            end else begin
                r_col <= r_col + 1'b1;
                if (r_col_ph == c_PH_LAST) begin
                    r_col_ph  <= '0;
                    r_col_idx <= r_col_idx + 1'b1;
                end else begin
                    r_col_ph <= r_col_ph + 1'b1;
                end
            end
        end
    end

    // Partial-max line buffer; contents need no reset because every entry
    // is overwritten by the first pixel of its window before being read
    always_ff @(posedge clk) begin
        if (w_in_fire && w_in_grid) begin
            r_buf[w_buf_idx] <= w_upd;
        end
    end

    // Output register: reload on emit, otherwise drop valid once consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_out_next;
            r_out_last  <= w_last_pos;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule : stream_max_pool
`default_nettype wire

// File: tb/tb_stream_max_pool.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_max_pool
//  Description : Self-checking bench for stream_max_pool. Three instances:
//                A 4x4/D1/K2, B 5x5/D1/K2, C 6x6/D3/K3. Honours
//                STREAM_MAX_POOL_RELU_EN in its expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_max_pool;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Instance A: 4x4, Depth 1, K 2
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [15:0] a_in_data, a_out_data;
    // Instance B: 5x5, Depth 1, K 2
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [15:0] b_in_data, b_out_data;
    // Instance C: 6x6, Depth 3, K 3
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last;
    logic [47:0] c_in_data, c_out_data;

    stream_max_pool #(.DATA_WIDTH(16), .InputH(4), .InputW(4), .Depth(1), .POOL_K(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last)
    );

    stream_max_pool #(.DATA_WIDTH(16), .InputH(5), .InputW(5), .Depth(1), .POOL_K(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last)
    );

    stream_max_pool #(.DATA_WIDTH(16), .InputH(6), .InputW(6), .Depth(3), .POOL_K(3)) u_dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_last(c_out_last)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic signed [15:0] relu(input logic signed [15:0] x);
`ifdef STREAM_MAX_POOL_RELU_EN
        return (x < 0) ? 16'sd0 : x;
`else
        return x;
`endif
    endfunction

    // Output monitors: record every completed output handshake
    logic [15:0] qa_d[$];
    logic        qa_l[$];
    logic [15:0] qb_d[$];
    logic        qb_l[$];
    logic [47:0] qc_d[$];
    logic        qc_l[$];

    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            qa_d.push_back(a_out_data);
            qa_l.push_back(a_out_last);
        end
        if (rst_n && b_out_valid && b_out_ready) begin
            qb_d.push_back(b_out_data);
            qb_l.push_back(b_out_last);
        end
        if (rst_n && c_out_valid && c_out_ready) begin
            qc_d.push_back(c_out_data);
            qc_l.push_back(c_out_last);
        end
    end

    typedef struct {
        logic [15:0] din;
        logic        ev;
        logic [15:0] ed;
        logic        el;
    } vec_t;

    vec_t        tbl [32];
    int          f2 [16] = '{-3, -7, 10, -20, -1, -9, -30, -4,
                             100, 200, -5, -6, 300, -400, -7, -8};
    logic [15:0] exp4 [4] = '{16'd5, 16'd7, 16'd13, 16'd15};
    logic [15:0] exp5 [4] = '{16'd6, 16'd8, 16'd16, 16'd18};
    logic [15:0] cpix [72][3];
    logic [47:0] c_exp [8];
    int          beat, hold, stalls;
    bit          started;

    // Stream a 4x4 ramp 0..15 into instance A with out_ready held high
    task automatic stream_a_ramp();
        beat = 0;
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && beat < 16; cyc++) begin
            a_in_valid = 1'b1;
            a_in_data  = 16'(beat);
            @(negedge clk);
            if (a_in_valid && a_in_ready) beat++;
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("ramp beats accepted", 48'(beat), 48'd16);
    endtask

    task automatic check_a_ramp(input string tag);
        check({tag, " count"}, 48'(qa_d.size()), 48'd4);
        for (int k = 0; k < 4 && k < qa_d.size(); k++) begin
            check($sformatf("%s out[%0d] data", tag, k), 48'(qa_d[k]), 48'(exp4[k]));
            check($sformatf("%s out[%0d] last", tag, k), 48'(qa_l[k]), 48'(k == 3));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b1;

        // ---------------- vector table: two 4x4 frames on A ----------------
        for (int i = 0; i < 16; i++) tbl[i] = '{din: 16'(i), ev: 1'b0, ed: 16'd0, el: 1'b0};
        tbl[5].ev  = 1'b1; tbl[5].ed  = 16'd5;
        tbl[7].ev  = 1'b1; tbl[7].ed  = 16'd7;
        tbl[13].ev = 1'b1; tbl[13].ed = 16'd13;
        tbl[15].ev = 1'b1; tbl[15].ed = 16'd15; tbl[15].el = 1'b1;
        for (int i = 0; i < 16; i++) tbl[16+i] = '{din: 16'(f2[i]), ev: 1'b0, ed: 16'd0, el: 1'b0};
        tbl[21].ev = 1'b1; tbl[21].ed = relu(-16'sd1);
        tbl[23].ev = 1'b1; tbl[23].ed = relu(16'sd10);
        tbl[29].ev = 1'b1; tbl[29].ed = relu(16'sd300);
        tbl[31].ev = 1'b1; tbl[31].ed = relu(-16'sd5); tbl[31].el = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", 48'(a_out_valid), 48'd0);
        check("reset out_data", 48'(a_out_data), 48'd0);
        check("reset out_last", 48'(a_out_last), 48'd0);
        check("reset in_ready", 48'(a_in_ready), 48'd1);
        check("reset C out_valid", 48'(c_out_valid), 48'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ---------------- apply table ----------------
        for (int i = 0; i < 32; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = tbl[i].din;
            @(negedge clk);
            check($sformatf("tbl[%0d] in_ready", i), 48'(a_in_ready), 48'd1);
            @(posedge clk); #1;
            check($sformatf("tbl[%0d] out_valid", i), 48'(a_out_valid), 48'(tbl[i].ev));
            if (tbl[i].ev) begin
                check($sformatf("tbl[%0d] out_data", i), 48'(a_out_data), 48'(tbl[i].ed));
                check($sformatf("tbl[%0d] out_last", i), 48'(a_out_last), 48'(tbl[i].el));
            end
        end
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        check("valid clears after drain", 48'(a_out_valid), 48'd0);

        // ---------------- backpressure on A ----------------
        qa_d.delete(); qa_l.delete();
        beat = 0; hold = 0; started = 1'b0;
        for (int cyc = 0; cyc < 200 && !(beat == 16 && qa_d.size() == 4); cyc++) begin
            if (a_out_valid && !started) begin
                started = 1'b1;
                hold = 5;
            end
            a_out_ready = (hold == 0);
            a_in_valid  = (beat < 16);
            a_in_data   = 16'(beat);
            @(negedge clk);
            if (hold > 0) begin
                check("bp in_ready", 48'(a_in_ready), 48'd0);
                check("bp out_valid", 48'(a_out_valid), 48'd1);
                check("bp out_data held", 48'(a_out_data), 48'd5);
                hold--;
            end
            if (a_in_valid && a_in_ready) beat++;
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        check("bp stall seen", 48'(started), 48'd1);
        check("bp beats accepted", 48'(beat), 48'd16);
        check_a_ramp("bp");

        // ---------------- reset mid-frame on A ----------------
        for (int i = 0; i < 7; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 16'(1000 + i);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset out_valid", 48'(a_out_valid), 48'd0);
        check("midreset in_ready", 48'(a_in_ready), 48'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        qa_d.delete(); qa_l.delete();
        stream_a_ramp();
        check_a_ramp("postreset");

        // ---------------- 5x5 with trailing row/col on B, two frames ----------------
        beat = 0; stalls = 0;
        for (int cyc = 0; cyc < 200 && beat < 50; cyc++) begin
            b_in_valid = 1'b1;
            if (((beat % 25) / 5) < 4 && (beat % 5) < 4)
                b_in_data = 16'(((beat % 25) / 5) * 5 + (beat % 5));
            else
                b_in_data = 16'd30000;
            @(negedge clk);
            if (!b_in_ready) stalls++;
            if (b_in_valid && b_in_ready) beat++;
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("5x5 beats accepted", 48'(beat), 48'd50);
        check("5x5 input stalls", 48'(stalls), 48'd0);
        check("5x5 count", 48'(qb_d.size()), 48'd8);
        for (int k = 0; k < 8 && k < qb_d.size(); k++) begin
            check($sformatf("5x5 out[%0d] data", k), 48'(qb_d[k]), 48'(exp5[k % 4]));
            check($sformatf("5x5 out[%0d] last", k), 48'(qb_l[k]), 48'((k % 4) == 3));
        end

        // ---------------- 6x6 Depth 3 K 3 random, two frames on C ----------------
        for (int i = 0; i < 72; i++)
            for (int ch = 0; ch < 3; ch++)
                cpix[i][ch] = 16'($urandom_range(0, 65535));
        for (int f = 0; f < 2; f++)
            for (int oy = 0; oy < 2; oy++)
                for (int ox = 0; ox < 2; ox++) begin
                    logic signed [15:0] m [3];
                    for (int ch = 0; ch < 3; ch++) begin
                        m[ch] = cpix[f*36 + oy*18 + ox*3][ch];
                        for (int ky = 0; ky < 3; ky++)
                            for (int kx = 0; kx < 3; kx++)
                                if ($signed(cpix[f*36 + (oy*3+ky)*6 + ox*3+kx][ch]) > m[ch])
                                    m[ch] = cpix[f*36 + (oy*3+ky)*6 + ox*3+kx][ch];
                    end
                    c_exp[f*4 + oy*2 + ox] = {16'(relu(m[0])), 16'(relu(m[1])), 16'(relu(m[2]))};
                end
        beat = 0;
        for (int cyc = 0; cyc < 3000 && !(beat == 72 && qc_d.size() == 8); cyc++) begin
            c_in_valid  = (beat < 72) && ($urandom_range(0, 4) != 0);
            c_in_data   = {cpix[(beat < 72) ? beat : 71][0],
                           cpix[(beat < 72) ? beat : 71][1],
                           cpix[(beat < 72) ? beat : 71][2]};
            c_out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (c_in_valid && c_in_ready) beat++;
            @(posedge clk); #1;
        end
        c_in_valid = 1'b0; c_out_ready = 1'b1;
        check("6x6 beats accepted", 48'(beat), 48'd72);
        check("6x6 count", 48'(qc_d.size()), 48'd8);
        for (int k = 0; k < 8 && k < qc_d.size(); k++) begin
            check($sformatf("6x6 out[%0d] data", k), qc_d[k], c_exp[k]);
            check($sformatf("6x6 out[%0d] last", k), 48'(qc_l[k]), 48'((k % 4) == 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_stream_max_pool
`default_nettype wire
